burst_deserializer: RTL and testbench
=====================================

Name: burst_deserializer

Overview:
- Receive-end counterpart of the burst clock generator.
- Captures a gated burst of WORD_W serial clock pulses, framed by an enable strobe, and assembles the serial data into a parallel word.
- Sits in the single system clock domain. Oversamples the asynchronous ser_en/ser_clk/ser_data lines.
- Hands completed words out through a valid/ready register, with framing-error and overrun reporting.

Parameters:
- WORD_W, 32, bits per burst and width of rd_data.
- SYNC_STAGES, 2, synchronizer flops on each serial input (min 2).
- MSB_FIRST, 1, 1 = first received bit lands in rd_data[WORD_W-1]; 0 = first bit lands in rd_data[0].

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ser_en  in  1  burst enable from transmitter, async; high for the whole burst.
- ser_clk  in  1  burst bit clock, async; data valid at its rising edge.
- ser_data  in  1  serial data, async.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_data  out  WORD_W  last completed word.
- rd_valid  out  1  rd_data holds an unconsumed word.
- frame_err  out  1  one-cycle pulse: burst ended with bit count != WORD_W.
- overrun  out  1  one-cycle pulse: new word overwrote an unconsumed word.
- bit_cnt  out  clog2(WORD_W+1)  bits received in the current burst (debug).

Behaviour:
- Reset (reset low, async): FSM=IDLE; shift reg, bit_cnt, rd_data = 0; rd_valid, frame_err, overrun = 0; all synchronizer and edge-history flops = 0.
- Sync and sampling:
  - ser_en, ser_clk and ser_data each pass through SYNC_STAGES flops, equal depth so they stay aligned.
  - One extra history flop per line for edge detection.
  - clk_rise = sync ser_clk 1 with history 0. en_rise / en_fall defined the same way on ser_en.
  - Requirement on the source: ser_clk high and low phases each >= 2 clk periods; ser_data stable >= 2 clk periods around each ser_clk rising edge.
- FSM IDLE:
  - clk_rise ignored.
  - en_rise -> RECV; shift reg and bit_cnt cleared.
  - A clk_rise in the same cycle as en_rise is captured as bit 0 and bit_cnt becomes 1.
- FSM RECV:
  - Each clk_rise shifts in the synced ser_data bit. MSB_FIRST=1: shift left, insert at LSB. MSB_FIRST=0: shift right, insert at MSB.
  - bit_cnt increments and saturates at WORD_W.
  - A clk_rise while bit_cnt==WORD_W sets an internal extra-bit flag; the shift reg is unchanged.
  - en_fall -> IDLE. A clk_rise in the same cycle is counted first, then the burst is evaluated.
  - Good burst (bit_cnt==WORD_W, extra flag clear): on the next edge, rd_data <= shift reg and rd_valid <= 1.
  - Any other count, or extra flag set: frame_err pulses 1 cycle; rd_data and rd_valid unchanged.
  - Extra flag clears on entry to IDLE.
- Latency: a ser_en falling edge at the pins gives rd_valid high after SYNC_STAGES+2 clk edges.
- Output handshake:
  - rd_valid && rd_ready on a cycle with no load: rd_valid -> 0; rd_data holds its value.
  - Load in the same cycle as accept: rd_valid stays 1 with the new data; no overrun.
  - Load while rd_valid=1 and rd_ready=0: new data replaces old; overrun pulses 1 cycle.
- Reset mid-burst: partial word discarded; after release, waits in IDLE for a fresh en_rise. A burst already in progress at release is ignored until ser_en goes low and high again.
- bit_cnt output reflects the internal count live; holds its last value in IDLE until the next en_rise.

Test Plan:
- Reset release, then 32 pulses on ser_clk (period 16 clk) with ser_data = 0xA5C3_0F81 MSB first, then ser_en low.
  - rd_valid high SYNC_STAGES+2 edges after the fall; rd_data = 0xA5C3_0F81; frame_err = 0.
- Burst of 31 pulses, then a burst of 33 pulses.
  - frame_err pulses once per burst; rd_valid stays 0; bit_cnt = 31, then 32 (saturated).
- Two good bursts 0x0000_0001 then 0xFFFF_FFFE with rd_ready = 0.
  - overrun pulses once; rd_data = 0xFFFF_FFFE; rd_valid = 1.
- rd_ready = 1 on the exact cycle the second word loads.
  - rd_valid stays 1; overrun = 0; first word consumed.
- reset asserted after the 10th bit of a burst, released while ser_en is still high.
  - No word and no frame_err from that burst; next full burst 0x1234_5678 received correctly.
- MSB_FIRST = 0 build, serial sequence 1,0,0,…,0.
  - rd_data = 0x0000_0001.

Source files
------------

// File: rtl/burst_deserializer_if.sv
// rtl/burst_deserializer_if.sv - parallel word hand-off and status bundle of the burst deserializer
interface burst_deserializer_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = $clog2(WORD_W + 1)
);
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              frame_err;
    logic              overrun;
    logic [CNT_W-1:0]  bit_cnt;

    modport master (
        output rd_data,
        output rd_valid,
        output frame_err,
        output overrun,
        output bit_cnt,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  frame_err,
        input  overrun,
        input  bit_cnt,
        output rd_ready
    );
endinterface

// File: rtl/burst_deserializer.sv
// rtl/burst_deserializer.sv - oversampling receiver for enable-framed serial clock bursts
module burst_deserializer #(
    parameter int WORD_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ser_en,
    input  logic                  ser_clk,
    input  logic                  ser_data,
    burst_deserializer_if.master  rd
);
    localparam int               CNT_W   = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_W);
    localparam int               SET_W   = $clog2(SYNC_STAGES + 1);
    localparam logic [SET_W-1:0] SET_MAX = SET_W'(SYNC_STAGES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] en_sync, clk_sync, data_sync;
    logic                   en_hist, clk_hist;
    logic                   en_s, clk_s, data_s;
    logic                   en_rise, en_fall, clk_rise;
    logic [SET_W-1:0]       settle_cnt;
    logic                   armed;
    logic                   en_start;

    logic [WORD_W-1:0]      shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   extra_q, extra_d;
    logic                   start_burst, take_bit, eval;
    logic                   good;

    logic [WORD_W-1:0]      rd_data_q;
    logic                   rd_valid_q, frame_err_q, overrun_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_sync   <= '0;
            clk_sync  <= '0;
            data_sync <= '0;
            en_hist   <= 1'b0;
            clk_hist  <= 1'b0;
        end else begin
            en_sync   <= {en_sync[SYNC_STAGES-2:0], ser_en};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ser_data};
            en_hist   <= en_sync[SYNC_STAGES-1];
            clk_hist  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign en_s     = en_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign en_rise  = en_s & ~en_hist;
    assign en_fall  = ~en_s & en_hist;
    assign clk_rise = clk_s & ~clk_hist;

    // A burst already running when reset is released must not be taken: only
    // arm once the synchronizers have filled and ser_en has been seen low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != SET_MAX)
                settle_cnt <= settle_cnt + SET_W'(1);
            if (settle_cnt == SET_MAX && !en_s)
                armed <= 1'b1;
        end
    end

    assign en_start = en_rise & armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en_start) state_d = S_RECV;
            S_RECV:  if (en_fall)  state_d = S_DONE;
            S_DONE:  state_d = en_start ? S_RECV : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // S_DONE is the one-cycle evaluation slot after en_fall, so a clk_rise
    // coinciding with the fall is already in cnt_q when the burst is judged.
    always_comb begin
        start_burst = 1'b0;
        take_bit    = 1'b0;
        eval        = 1'b0;
        case (state_q)
            S_IDLE: begin
                start_burst = en_start;
                take_bit    = en_start & clk_rise;
            end
            S_RECV: begin
                take_bit    = clk_rise;
            end
            S_DONE: begin
                eval        = 1'b1;
                start_burst = en_start;
                take_bit    = en_start & clk_rise;
            end
            default: ;
        endcase
    end

    always_comb begin
        shift_d = start_burst ? '0 : shift_q;
        cnt_d   = start_burst ? '0 : cnt_q;
        extra_d = (start_burst || eval) ? 1'b0 : extra_q;
        if (take_bit) begin
            if (cnt_d == CNT_MAX) begin
                extra_d = 1'b1;
            end else begin
                if (MSB_FIRST)
                    shift_d = {shift_d[WORD_W-2:0], data_s};
                else
                    shift_d = {data_s, shift_d[WORD_W-1:1]};
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            extra_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            extra_q <= extra_d;
        end
    end

    assign good = eval && (cnt_q == CNT_MAX) && !extra_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= eval && !good;
            overrun_q   <= 1'b0;
            if (good) begin
                rd_data_q  <= shift_q;
                rd_valid_q <= 1'b1;
                overrun_q  <= rd_valid_q && !rd.rd_ready;
            end else if (rd_valid_q && rd.rd_ready) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign rd.rd_data   = rd_data_q;
    assign rd.rd_valid  = rd_valid_q;
    assign rd.frame_err = frame_err_q;
    assign rd.overrun   = overrun_q;
    assign rd.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_burst_deserializer.sv
// tb/tb_burst_deserializer.sv - bench for burst_deserializer, MSB-first and LSB-first builds side by side
module tb_burst_deserializer;
    logic clk = 1'b0;
    logic rst_n;
    logic ser_en, ser_clk, ser_data, rd_ready;

    always #5 clk = ~clk;

    burst_deserializer_if #(.WORD_W(32)) bus_m ();
    burst_deserializer_if #(.WORD_W(32)) bus_l ();
    assign bus_m.rd_ready = rd_ready;
    assign bus_l.rd_ready = rd_ready;

    burst_deserializer #(.WORD_W(32), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(rst_n), .ser_en(ser_en), .ser_clk(ser_clk),
        .ser_data(ser_data), .rd(bus_m.master));

    burst_deserializer #(.WORD_W(32), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(rst_n), .ser_en(ser_en), .ser_clk(ser_clk),
        .ser_data(ser_data), .rd(bus_l.master));

    int n_tests = 0;
    int n_fail  = 0;
    int ferr_m = 0, ovr_m = 0, ferr_l = 0, ovr_l = 0;

    always @(negedge clk) begin
        if (bus_m.frame_err) ferr_m <= ferr_m + 1;
        if (bus_m.overrun)   ovr_m  <= ovr_m + 1;
        if (bus_l.frame_err) ferr_l <= ferr_l + 1;
        if (bus_l.overrun)   ovr_l  <= ovr_l + 1;
    end

    // reference model: bits of the current burst and the expected output register
    bit          q_bits[$];
    logic        m_valid;
    logic [31:0] m_data_m, m_data_l;
    int          m_ferr, m_ovr;

    typedef struct {
        int          nbits;
        logic [31:0] word;
        logic        consume;
        int          exp_cnt;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] exp_data_l;
        int          exp_ferr_inc;
        int          exp_ovr_inc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pack_msb();
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], q_bits[i]};
        return w;
    endfunction

    function automatic logic [31:0] pack_lsb();
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) w[i] = q_bits[i];
        return w;
    endfunction

    task automatic model_end_burst(input logic ready_at_load);
        if (q_bits.size() == 32) begin
            if (m_valid && !ready_at_load) m_ovr++;
            m_valid  = 1'b1;
            m_data_m = pack_msb();
            m_data_l = pack_lsb();
        end else begin
            m_ferr++;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " valid_m"}, bus_m.rd_valid, m_valid);
        check({tag, " valid_l"}, bus_l.rd_valid, m_valid);
        check({tag, " data_m"}, bus_m.rd_data, m_data_m);
        check({tag, " data_l"}, bus_l.rd_data, m_data_l);
        check({tag, " ferr_m"}, ferr_m, m_ferr);
        check({tag, " ferr_l"}, ferr_l, m_ferr);
        check({tag, " ovr_m"}, ovr_m, m_ovr);
        check({tag, " ovr_l"}, ovr_l, m_ovr);
    endtask

    task automatic start_burst();
        q_bits.delete();
        ser_en = 1'b1;
        tick(4);
    endtask

    task automatic pulse_bits(input logic [31:0] w, input int first, input int n);
        bit b;
        for (int i = first; i < first + n; i++) begin
            b = (i < 32) ? w[31-i] : 1'($urandom_range(0, 1));
            ser_data = b;
            q_bits.push_back(b);
            tick(4);
            ser_clk = 1'b1;
            tick(8);
            ser_clk = 1'b0;
            tick(4);
        end
    endtask

    task automatic end_burst(output int lat);
        logic was_valid;
        was_valid = bus_m.rd_valid;
        ser_en = 1'b0;
        lat = 0;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            if (lat == 0 && !was_valid && bus_m.rd_valid) lat = e;
        end
        tick(4);
    endtask

    task automatic consume();
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        m_valid = 1'b0;
    endtask

    initial begin
        int lat, f0, o0, len;
        logic [31:0] w;

        vecs[0] = '{32, 32'hA5C3_0F81, 1'b1, 32, 1'b1, 32'hA5C3_0F81, 32'h81F0_C3A5, 0, 0, 4};
        vecs[1] = '{31, 32'h1234_5678, 1'b0, 31, 1'b0, 32'hA5C3_0F81, 32'h81F0_C3A5, 1, 0, 0};
        vecs[2] = '{33, 32'hFFFF_FFFF, 1'b0, 32, 1'b0, 32'hA5C3_0F81, 32'h81F0_C3A5, 1, 0, 0};
        vecs[3] = '{32, 32'h0000_0001, 1'b0, 32, 1'b1, 32'h0000_0001, 32'h8000_0000, 0, 0, 4};
        vecs[4] = '{32, 32'hFFFF_FFFE, 1'b1, 32, 1'b1, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 0, 1, 0};
        vecs[5] = '{32, 32'h8000_0000, 1'b1, 32, 1'b1, 32'h8000_0000, 32'h0000_0001, 0, 0, 4};

        rst_n = 1'b0; ser_en = 1'b0; ser_clk = 1'b0; ser_data = 1'b0; rd_ready = 1'b0;
        m_valid = 1'b0; m_data_m = '0; m_data_l = '0; m_ferr = 0; m_ovr = 0;
        tick(3);
        check("reset rd_valid", bus_m.rd_valid, 1'b0);
        check("reset rd_data", bus_m.rd_data, 32'h0);
        check("reset bit_cnt", bus_m.bit_cnt, 6'd0);
        check("reset frame_err", bus_m.frame_err, 1'b0);
        check("reset overrun", bus_m.overrun, 1'b0);
        rst_n = 1'b1;
        tick(6);
        check_model("post reset");

        foreach (vecs[k]) begin
            f0 = ferr_m;
            o0 = ovr_m;
            start_burst();
            pulse_bits(vecs[k].word, 0, vecs[k].nbits);
            check($sformatf("vec%0d bit_cnt live", k), bus_m.bit_cnt, vecs[k].exp_cnt);
            model_end_burst(1'b0);
            end_burst(lat);
            if (vecs[k].exp_lat != 0)
                check($sformatf("vec%0d latency", k), lat, vecs[k].exp_lat);
            check($sformatf("vec%0d bit_cnt hold", k), bus_m.bit_cnt, vecs[k].exp_cnt);
            check($sformatf("vec%0d rd_valid", k), bus_m.rd_valid, vecs[k].exp_valid);
            check($sformatf("vec%0d rd_data", k), bus_m.rd_data, vecs[k].exp_data);
            check($sformatf("vec%0d rd_data lsb", k), bus_l.rd_data, vecs[k].exp_data_l);
            check($sformatf("vec%0d frame_err", k), ferr_m - f0, vecs[k].exp_ferr_inc);
            check($sformatf("vec%0d overrun", k), ovr_m - o0, vecs[k].exp_ovr_inc);
            check_model($sformatf("vec%0d", k));
            if (vecs[k].consume) begin
                consume();
                check($sformatf("vec%0d consumed", k), bus_m.rd_valid, 1'b0);
                check($sformatf("vec%0d data held", k), bus_m.rd_data, vecs[k].exp_data);
            end
        end

        // reset after the 10th bit, released while ser_en is still high
        start_burst();
        pulse_bits(32'hDEAD_BEEF, 0, 10);
        rst_n = 1'b0;
        tick(3);
        m_valid = 1'b0; m_data_m = '0; m_data_l = '0;
        check("midreset bit_cnt", bus_m.bit_cnt, 6'd0);
        rst_n = 1'b1;
        pulse_bits(32'hDEAD_BEEF, 10, 22);
        check("midreset ignored bits", bus_m.bit_cnt, 6'd0);
        end_burst(lat);
        check("midreset no word", lat, 0);
        check_model("midreset");
        start_burst();
        pulse_bits(32'h1234_5678, 0, 32);
        model_end_burst(1'b0);
        end_burst(lat);
        check("after reset data", bus_m.rd_data, 32'h1234_5678);
        check_model("after reset");

        // rd_ready high exactly on the cycle the next word loads
        o0 = ovr_m;
        start_burst();
        pulse_bits(32'h0F0F_F0F0, 0, 32);
        ser_en = 1'b0;
        tick(3);
        check("pre-load data", bus_m.rd_data, 32'h1234_5678);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        check("load+accept valid", bus_m.rd_valid, 1'b1);
        check("load+accept data", bus_m.rd_data, 32'h0F0F_F0F0);
        model_end_burst(1'b1);
        tick(3);
        check("load+accept overrun", ovr_m - o0, 0);
        check_model("load+accept");
        consume();
        check_model("load+accept drained");

        for (int it = 0; it < 24; it++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(28, 36)) : 32;
            w = $urandom;
            start_burst();
            pulse_bits(w, 0, len);
            check($sformatf("rand%0d bit_cnt", it), bus_m.bit_cnt, (len > 32) ? 32 : len);
            model_end_burst(1'b0);
            end_burst(lat);
            check_model($sformatf("rand%0d", it));
            if ($urandom_range(0, 1) == 1) consume();
        end
        tick(2);
        check_model("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
